// File: rtl/hidden_instr_fetch_pkg.sv
// hidden_cpu_pkg: shared constants, field slices and FSM encoding for the instruction fetch stage
package hidden_cpu_pkg;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = 6;
  localparam int OP_HI = 5;
  localparam int OP_LO = 4;
  localparam int R0_HI = 3;
  localparam int R0_LO = 2;
  localparam int R1_HI = 1;
  localparam int R1_LO = 0;
  localparam logic [AW:0] LEN_FULL = (AW + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
endpackage

// File: rtl/hidden_instr_fetch_if.sv
// hidden_instr_fetch_if: load/control/fetch bundle between the fetch stage and its neighbours
interface hidden_instr_fetch_if;
  import hidden_cpu_pkg::*;
  logic load_req;
  logic wr_en;
  logic [IW-1:0] wr_data;
  logic start;
  logic abort;
  logic step_mode;
  logic step;
  logic [7:0] pc_in;
  logic [IW-1:0] instr;
  logic instr_vld;
  logic [1:0] state;
  logic [AW:0] prog_len;
  logic overflow;
  modport master (
    output load_req, wr_en, wr_data, start, abort, step_mode, step, pc_in,
    input instr, instr_vld, state, prog_len, overflow
  );
  modport slave (
    input load_req, wr_en, wr_data, start, abort, step_mode, step, pc_in,
    output instr, instr_vld, state, prog_len, overflow
  );
endinterface

// File: rtl/hidden_prog_ram.sv
// hidden_prog_ram: DEPTH x IW program store, sync write, registered read; array contents survive rst
module hidden_prog_ram
  import hidden_cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic re,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [IW-1:0] wdata,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] mem [DEPTH];
  // program array: written only while loading, never cleared
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register doubles as the instruction output; holds between fetches
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/hidden_instr_fetch.sv
// hidden_instr_fetch: loads a program from the pins, then replays it by PC with optional single-step
module hidden_instr_fetch
  import hidden_cpu_pkg::*;
(
  input logic clk,
  input logic rst,
  hidden_instr_fetch_if.slave bus
);
  state_t st, nxt;
  logic [AW:0] len;
  logic ovf, vld, vld_d, we, re, clr, full, fe, in_rng;
  assign full = len == LEN_FULL;
  assign fe = bus.step_mode ? bus.step : 1'b1;
  assign in_rng = 8'(len) > bus.pc_in;
  assign we = st == LOAD && bus.wr_en && !full;
  assign bus.state = st;
  assign bus.prog_len = len;
  assign bus.overflow = ovf;
  assign bus.instr_vld = vld;
  // next state and per-cycle fetch/clear controls; abort outranks start and step
  always_comb begin
    nxt = st;
    re = 1'b0;
    vld_d = 1'b0;
    clr = 1'b0;
    case (st)
      IDLE:
        if (bus.load_req) begin
          nxt = LOAD;
          clr = 1'b1;
        end else if (bus.start && len != '0) nxt = RUN;
      LOAD: nxt = bus.start && (len != '0 || we) ? RUN : LOAD;
      RUN:
        if (bus.abort) nxt = IDLE;
        else if (fe && in_rng) begin
          re = 1'b1;
          vld_d = 1'b1;
        end else if (fe) nxt = HALT;
      HALT:
        if (bus.abort) nxt = IDLE;
        else if (bus.load_req) begin
          nxt = LOAD;
          clr = 1'b1;
        end else if (bus.start) nxt = RUN;
      default: nxt = IDLE;
    endcase
  end
  // state, valid flag, program length (doubles as write pointer) and sticky overflow
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      vld <= 1'b0;
      len <= '0;
      ovf <= 1'b0;
    end else begin
      st <= nxt;
      vld <= vld_d;
      if (clr) begin
        len <= '0;
        ovf <= 1'b0;
      end else if (we) len <= len + 1'b1;
      else if (st == LOAD && bus.wr_en && full) ovf <= 1'b1;
    end
  hidden_prog_ram u_ram (
    .clk(clk),
    .rst(rst),
    .we(we),
    .re(re),
    .waddr(len[AW-1:0]),
    .raddr(bus.pc_in[AW-1:0]),
    .wdata(bus.wr_data),
    .rdata(bus.instr)
  );
endmodule

// File: tb/tb_hidden_instr_fetch.sv
// tb_hidden_instr_fetch: directed scenarios plus random traffic checked every cycle against a program model
module tb_hidden_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  hidden_instr_fetch_if bus();
  hidden_instr_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [5:0] m_mem [16];
  logic [1:0] m_st = 2'd0;
  logic [4:0] m_len = 5'd0;
  logic m_ovf = 1'b0;
  logic m_vld = 1'b0;
  logic [5:0] m_ins = 6'd0;
  // reference: what the fetch stage must do, written from the behavioural rules
  always @(posedge clk) begin
    if (rst) begin
      m_st = 2'd0; m_len = 5'd0; m_ovf = 1'b0; m_ins = 6'd0; m_vld = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (m_st == 2'd0) begin
        if (bus.load_req) begin m_st = 2'd1; m_len = 5'd0; m_ovf = 1'b0; end
        else if (bus.start && m_len > 0) m_st = 2'd2;
      end else if (m_st == 2'd1) begin
        if (bus.wr_en) begin
          if (m_len < 16) begin m_mem[m_len[3:0]] = bus.wr_data; m_len = m_len + 5'd1; end
          else m_ovf = 1'b1;
        end
        if (bus.start && m_len > 0) m_st = 2'd2;
      end else if (m_st == 2'd2) begin
        if (bus.abort) m_st = 2'd0;
        else if (!bus.step_mode || bus.step) begin
          if (int'(bus.pc_in) < int'(m_len)) begin m_ins = m_mem[bus.pc_in % 16]; m_vld = 1'b1; end
          else m_st = 2'd3;
        end
      end else begin
        if (bus.abort) m_st = 2'd0;
        else if (bus.load_req) begin m_st = 2'd1; m_len = 5'd0; m_ovf = 1'b0; end
        else if (bus.start) m_st = 2'd2;
      end
    end
  end
  // every-cycle comparison of all outputs against the model
  always @(posedge clk) begin
    #1;
    checks++;
    if (bus.state !== m_st || bus.prog_len !== m_len || bus.overflow !== m_ovf ||
        bus.instr_vld !== m_vld || bus.instr !== m_ins) begin
      failures++;
      $display("FAIL model t=%0t dut st=%0d len=%0d ovf=%0b vld=%0b ins=%h want st=%0d len=%0d ovf=%0b vld=%0b ins=%h",
        $time, bus.state, bus.prog_len, bus.overflow, bus.instr_vld, bus.instr,
        m_st, m_len, m_ovf, m_vld, m_ins);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string name, input logic [7:0] dv, input logic [7:0] mv, input logic [7:0] exp);
    checks += 2;
    if (dv !== exp) begin failures++; $display("FAIL %s dut=%h want=%h", name, dv, exp); end
    if (mv !== exp) begin failures++; $display("FAIL %s model=%h want=%h", name, mv, exp); end
  endtask
  task automatic wr(input logic [5:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    cyc();
    bus.wr_en = 1'b0;
  endtask
  task automatic pulse_load();
    bus.load_req = 1'b1; cyc(); bus.load_req = 1'b0;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask
  task automatic fetch(input logic [7:0] pc);
    bus.pc_in = pc; cyc();
  endtask
  initial begin
    bus.load_req = 0; bus.wr_en = 0; bus.wr_data = 0; bus.start = 0; bus.abort = 0;
    bus.step_mode = 0; bus.step = 0; bus.pc_in = 0;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_state", 8'(bus.state), 8'(m_st), 8'd0);
    chk("reset_vld", 8'(bus.instr_vld), 8'(m_vld), 8'd0);
    chk("reset_len", 8'(bus.prog_len), 8'(m_len), 8'd0);
    pulse_load();
    wr(6'h11); wr(6'h22); wr(6'h3F);
    pulse_start();
    chk("t1_run", 8'(bus.state), 8'(m_st), 8'd2);
    fetch(8'd0); chk("t1_i0", 8'(bus.instr), 8'(m_ins), 8'h11);
    chk("t1_v0", 8'(bus.instr_vld), 8'(m_vld), 8'd1);
    fetch(8'd1); chk("t1_i1", 8'(bus.instr), 8'(m_ins), 8'h22);
    fetch(8'd2); chk("t1_i2", 8'(bus.instr), 8'(m_ins), 8'h3F);
    fetch(8'd3); chk("t1_halt", 8'(bus.state), 8'(m_st), 8'd3);
    chk("t1_hvld", 8'(bus.instr_vld), 8'(m_vld), 8'd0);
    chk("t1_hold", 8'(bus.instr), 8'(m_ins), 8'h3F);
    bus.pc_in = 8'd0;
    pulse_start();
    fetch(8'd0); chk("t6_refetch", 8'(bus.instr), 8'(m_ins), 8'h11);
    bus.abort = 1'b1; bus.start = 1'b1; cyc(); bus.abort = 1'b0; bus.start = 1'b0;
    chk("t6_abort", 8'(bus.state), 8'(m_st), 8'd0);
    pulse_load();
    for (int i = 0; i < 17; i++) wr(6'(i + 5));
    chk("t2_len", 8'(bus.prog_len), 8'(m_len), 8'd16);
    chk("t2_ovf", 8'(bus.overflow), 8'(m_ovf), 8'd1);
    pulse_start();
    fetch(8'd0); chk("t2_ram0", 8'(bus.instr), 8'(m_ins), 8'h05);
    fetch(8'd15); chk("t2_ram15", 8'(bus.instr), 8'(m_ins), 8'h14);
    fetch(8'd16); chk("t2_halt", 8'(bus.state), 8'(m_st), 8'd3);
    bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
    pulse_load();
    wr(6'h04); wr(6'h15); wr(6'h26); wr(6'h37);
    bus.step_mode = 1'b1; bus.pc_in = 8'd1;
    pulse_start();
    for (int c = 0; c < 7; c++) begin
      bus.step = (c == 2 || c == 5);
      cyc();
      chk("t3_step_vld", 8'(bus.instr_vld), 8'(m_vld), (c == 2 || c == 5) ? 8'd1 : 8'd0);
      bus.step = 1'b0;
    end
    chk("t3_ins", 8'(bus.instr), 8'(m_ins), 8'h15);
    bus.step_mode = 1'b0;
    bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
    pulse_load();
    bus.wr_en = 1'b1; bus.wr_data = 6'h2A; bus.start = 1'b1; bus.pc_in = 8'd0;
    cyc();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    chk("t4_run", 8'(bus.state), 8'(m_st), 8'd2);
    chk("t4_len", 8'(bus.prog_len), 8'(m_len), 8'd1);
    fetch(8'd0); chk("t4_ins", 8'(bus.instr), 8'(m_ins), 8'h2A);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_idle", 8'(bus.state), 8'(m_st), 8'd0);
    chk("t5_len", 8'(bus.prog_len), 8'(m_len), 8'd0);
    chk("t5_vld", 8'(bus.instr_vld), 8'(m_vld), 8'd0);
    pulse_start();
    chk("t5_ign", 8'(bus.state), 8'(m_st), 8'd0);
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.load_req = ($urandom_range(0, 24) == 0);
      bus.wr_en = $urandom_range(0, 1) == 1;
      bus.wr_data = 6'($urandom);
      bus.start = ($urandom_range(0, 14) == 0);
      bus.abort = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) bus.step_mode = ~bus.step_mode;
      bus.step = ($urandom_range(0, 2) == 0);
      bus.pc_in = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, int'(m_len) + 1));
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
